// File: rtl/add_sub_serial_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Optional feature macro used across the slice: ADD_SUB_OVF_EN (signed overflow output).
package add_sub_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_sub_serial_if.sv
// Start/ready request bus and result outputs of add_sub_serial.
// ADD_SUB_OVF_EN adds the overflow_out signal to both modports.
interface add_sub_serial_if #(
    parameter int unsigned WIDTH = add_sub_pkg::DEF_WIDTH
);

    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             control_in;
    logic             ready_out;
    logic             done_out;
    logic [WIDTH-1:0] result_out;
    logic             carry_out;
`ifdef ADD_SUB_OVF_EN
    logic             overflow_out;

    modport master (
        output start_in, a_in, b_in, control_in,
        input  ready_out, done_out, result_out, carry_out, overflow_out
    );

    modport slave (
        input  start_in, a_in, b_in, control_in,
        output ready_out, done_out, result_out, carry_out, overflow_out
    );
`else
    modport master (
        output start_in, a_in, b_in, control_in,
        input  ready_out, done_out, result_out, carry_out
    );

    modport slave (
        input  start_in, a_in, b_in, control_in,
        output ready_out, done_out, result_out, carry_out
    );
`endif

endinterface

// File: rtl/add_sub_serial_fa.sv
// Single-bit full adder; shared with the combinational adder library.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_sub_serial.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through one full adder.
// Define ADD_SUB_OVF_EN to add the registered signed-overflow output.
module add_sub_serial
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    add_sub_serial_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
`ifdef ADD_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;

    full_adder_1bit u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
`ifdef ADD_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            c_q      <= c_d;
            result_q <= result_d;
            carry_q  <= carry_d;
`ifdef ADD_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Subtract loads ~B with carry-in 1, giving A + ~B + 1 = A - B.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        c_d      = c_q;
        result_d = result_q;
        carry_d  = carry_q;
`ifdef ADD_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    a_sr_d  = bus.a_in;
                    b_sr_d  = (bus.control_in == OP_SUB) ? ~bus.b_in : bus.b_in;
                    c_d     = bus.control_in;
                end
            end
            BUSY: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                c_d      = fa_cout;
                res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = {fa_sum, res_sr_q[WIDTH-1:1]};
                    carry_d  = fa_cout;
`ifdef ADD_SUB_OVF_EN
                    ovf_d    = c_q ^ fa_cout;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready_out  = (state_q == IDLE);
    assign bus.done_out   = (state_q == DONE);
    assign bus.result_out = result_q;
    assign bus.carry_out  = carry_q;
`ifdef ADD_SUB_OVF_EN
    assign bus.overflow_out = ovf_q;
`endif

endmodule
